// File: rtl/branch_target_rs.sv
// Reservation station for branch/jump target computation with tag-tracked operands,
// oldest-ready dispatch and an output FIFO drained by the branch resolution table.
module branch_target_rs #(
  parameter int RSDEPTH = 8,
  parameter int ROBW    = 8,
  parameter int NBC     = 2,
  parameter int OFDEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         i_flush,
  input  logic                         i_wr_en,
  input  logic [ROBW-1:0]              i_wr_rob_addr,
  input  logic                         i_wr_jalr,
  input  logic [31:0]                  i_wr_op1,
  input  logic [ROBW-1:0]              i_wr_op1_tag,
  input  logic                         i_wr_op1_v,
  input  logic [31:0]                  i_wr_op2,
  input  logic [ROBW-1:0]              i_wr_op2_tag,
  input  logic                         i_wr_op2_v,
  input  logic [NBC-1:0]               i_bc_valid,
  input  logic [NBC*ROBW-1:0]          i_bc_rob_addr,
  input  logic [NBC*32-1:0]            i_bc_data,
  output logic                         o_full,
  output logic [$clog2(RSDEPTH+1)-1:0] o_count,
  output logic                         o_empty,
  output logic [31:0]                  o_target,
  output logic [ROBW-1:0]              o_rob_addr,
  input  logic                         i_rd_en
);
  localparam int CW = $clog2(RSDEPTH+1);
  localparam int IW = $clog2(RSDEPTH);
  localparam int PW = $clog2(OFDEPTH);
  localparam int FW = $clog2(OFDEPTH+1);

  logic [RSDEPTH-1:0] valid, op1_v, op2_v, jalr, ready;
  logic [ROBW-1:0]    rob_addr [RSDEPTH];
  logic [ROBW-1:0]    tag1     [RSDEPTH];
  logic [ROBW-1:0]    tag2     [RSDEPTH];
  logic [31:0]        op1      [RSDEPTH];
  logic [31:0]        op2      [RSDEPTH];
  // older[a][b] set means entry a was allocated before entry b
  logic [RSDEPTH-1:0] older    [RSDEPTH];

  logic [31:0]        fifo_target [OFDEPTH];
  logic [ROBW-1:0]    fifo_rob    [OFDEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [FW-1:0]      fifo_cnt;

  logic [CW-1:0]      valid_cnt;
  logic [IW-1:0]      alloc_idx, disp_idx;
  logic               any_ready, do_alloc, do_disp, do_pop, fifo_full;
  logic [31:0]        wr_op1_d, wr_op2_d, disp_sum, disp_target;
  logic               wr_op1_vd, wr_op2_vd;

  assign ready = valid & op1_v & op2_v;

  always_comb begin
    valid_cnt = '0;
    for (int i = 0; i < RSDEPTH; i++) valid_cnt = valid_cnt + CW'(valid[i]);
  end

  assign o_count = valid_cnt;
  assign o_full  = &valid;

  always_comb begin
    logic found;
    logic blocked;
    found     = 1'b0;
    blocked   = 1'b0;
    alloc_idx = '0;
    disp_idx  = '0;
    any_ready = 1'b0;
    for (int i = 0; i < RSDEPTH; i++) begin
      if (!valid[i] && !found) begin
        alloc_idx = IW'(i);
        found     = 1'b1;
      end
    end
    // An entry is the oldest ready one when no other ready entry is older than it
    for (int i = 0; i < RSDEPTH; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < RSDEPTH; j++) begin
        if (j != i && ready[j] && older[j][i]) blocked = 1'b1;
      end
      if (ready[i] && !blocked) begin
        disp_idx  = IW'(i);
        any_ready = 1'b1;
      end
    end
  end

  // Descending scan so the lowest matching channel is the one that sticks
  always_comb begin
    wr_op1_d  = i_wr_op1;
    wr_op1_vd = i_wr_op1_v;
    wr_op2_d  = i_wr_op2;
    wr_op2_vd = i_wr_op2_v;
    for (int k = NBC-1; k >= 0; k--) begin
      if (!i_wr_op1_v && i_bc_valid[k] && i_bc_rob_addr[k*ROBW +: ROBW] == i_wr_op1_tag) begin
        wr_op1_d  = i_bc_data[k*32 +: 32];
        wr_op1_vd = 1'b1;
      end
      if (!i_wr_op2_v && i_bc_valid[k] && i_bc_rob_addr[k*ROBW +: ROBW] == i_wr_op2_tag) begin
        wr_op2_d  = i_bc_data[k*32 +: 32];
        wr_op2_vd = 1'b1;
      end
    end
  end

  assign fifo_full   = (fifo_cnt == FW'(OFDEPTH));
  assign do_pop      = i_rd_en && (fifo_cnt != '0);
  assign do_alloc    = i_wr_en && !o_full;
  assign do_disp     = any_ready && (!fifo_full || i_rd_en);
  assign disp_sum    = op1[disp_idx] + op2[disp_idx];
  assign disp_target = {disp_sum[31:1], disp_sum[0] & ~jalr[disp_idx]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= '0;
      op1_v <= '0;
      op2_v <= '0;
      jalr  <= '0;
      for (int i = 0; i < RSDEPTH; i++) begin
        rob_addr[i] <= '0;
        tag1[i]     <= '0;
        tag2[i]     <= '0;
        op1[i]      <= '0;
        op2[i]      <= '0;
        older[i]    <= '0;
      end
    end else if (i_flush) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < RSDEPTH; i++) begin
        if (do_disp && disp_idx == IW'(i)) begin
          valid[i] <= 1'b0;
        end else if (do_alloc && alloc_idx == IW'(i)) begin
          valid[i]    <= 1'b1;
          rob_addr[i] <= i_wr_rob_addr;
          jalr[i]     <= i_wr_jalr;
          op1[i]      <= wr_op1_d;
          op1_v[i]    <= wr_op1_vd;
          tag1[i]     <= i_wr_op1_tag;
          op2[i]      <= wr_op2_d;
          op2_v[i]    <= wr_op2_vd;
          tag2[i]     <= i_wr_op2_tag;
          older[i]    <= '0;
        end else if (valid[i]) begin
          for (int k = NBC-1; k >= 0; k--) begin
            if (!op1_v[i] && i_bc_valid[k] && i_bc_rob_addr[k*ROBW +: ROBW] == tag1[i]) begin
              op1[i]   <= i_bc_data[k*32 +: 32];
              op1_v[i] <= 1'b1;
            end
            if (!op2_v[i] && i_bc_valid[k] && i_bc_rob_addr[k*ROBW +: ROBW] == tag2[i]) begin
              op2[i]   <= i_bc_data[k*32 +: 32];
              op2_v[i] <= 1'b1;
            end
          end
        end
      end
      if (do_alloc) begin
        for (int j = 0; j < RSDEPTH; j++) begin
          if (IW'(j) != alloc_idx) older[j][alloc_idx] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (i_flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (do_disp) wr_ptr <= (wr_ptr == PW'(OFDEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(OFDEPTH-1)) ? '0 : rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + FW'(do_disp) - FW'(do_pop);
    end
  end

  // Storage needs no reset: the head outputs are forced to zero while empty
  always_ff @(posedge clk) begin
    if (!i_flush && do_disp) begin
      fifo_target[wr_ptr] <= disp_target;
      fifo_rob[wr_ptr]    <= rob_addr[disp_idx];
    end
  end

  assign o_empty    = (fifo_cnt == '0);
  assign o_target   = o_empty ? '0 : fifo_target[rd_ptr];
  assign o_rob_addr = o_empty ? '0 : fifo_rob[rd_ptr];

endmodule

// File: tb/tb_branch_target_rs.sv
// Bench for branch_target_rs: hand-computed vector table, directed corner sequences,
// and random traffic checked against a queue-based age-ordered model.
module tb_branch_target_rs;
  localparam int RSDEPTH = 8;
  localparam int ROBW    = 8;
  localparam int NBC     = 2;
  localparam int OFDEPTH = 4;

  typedef struct {
    bit          flush, wr, jalr, v1, v2, rd;
    logic [7:0]  rob, t1, t2, bt0, bt1;
    logic [31:0] op1, op2, bd0, bd1;
    logic [1:0]  bcv;
  } stim_t;

  typedef struct {
    stim_t       s;
    int          cnt;
    bit          empty;
    logic [31:0] tgt;
    logic [7:0]  rob;
  } vec_t;

  typedef struct {
    logic [7:0]  rob, t1, t2;
    bit          jalr, v1, v2;
    logic [31:0] o1, o2;
  } ment_t;

  typedef struct {
    logic [31:0] tgt;
    logic [7:0]  rob;
  } fent_t;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 i_flush, i_wr_en, i_wr_jalr, i_wr_op1_v, i_wr_op2_v, i_rd_en;
  logic [ROBW-1:0]      i_wr_rob_addr, i_wr_op1_tag, i_wr_op2_tag;
  logic [31:0]          i_wr_op1, i_wr_op2;
  logic [NBC-1:0]       i_bc_valid;
  logic [NBC*ROBW-1:0]  i_bc_rob_addr;
  logic [NBC*32-1:0]    i_bc_data;
  logic                 o_full, o_empty;
  logic [3:0]           o_count;
  logic [31:0]          o_target;
  logic [ROBW-1:0]      o_rob_addr;

  int    pass_cnt = 0;
  int    total_cnt = 0;
  ment_t mq[$];
  fent_t fq[$];
  vec_t  tbl[16];

  always #5 clk = ~clk;

  branch_target_rs #(.RSDEPTH(RSDEPTH), .ROBW(ROBW), .NBC(NBC), .OFDEPTH(OFDEPTH)) dut (
    .clk(clk), .rstn(rstn), .i_flush(i_flush), .i_wr_en(i_wr_en),
    .i_wr_rob_addr(i_wr_rob_addr), .i_wr_jalr(i_wr_jalr),
    .i_wr_op1(i_wr_op1), .i_wr_op1_tag(i_wr_op1_tag), .i_wr_op1_v(i_wr_op1_v),
    .i_wr_op2(i_wr_op2), .i_wr_op2_tag(i_wr_op2_tag), .i_wr_op2_v(i_wr_op2_v),
    .i_bc_valid(i_bc_valid), .i_bc_rob_addr(i_bc_rob_addr), .i_bc_data(i_bc_data),
    .o_full(o_full), .o_count(o_count), .o_empty(o_empty),
    .o_target(o_target), .o_rob_addr(o_rob_addr), .i_rd_en(i_rd_en)
  );

  function automatic stim_t idle_s();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t wr_s(logic [7:0] rob, bit jalr, logic [31:0] op1, bit v1,
                                 logic [7:0] t1, logic [31:0] op2, bit v2, logic [7:0] t2);
    stim_t s;
    s = idle_s();
    s.wr = 1'b1; s.rob = rob; s.jalr = jalr;
    s.op1 = op1; s.v1 = v1; s.t1 = t1;
    s.op2 = op2; s.v2 = v2; s.t2 = t2;
    return s;
  endfunction

  function automatic stim_t rd_s();
    stim_t s;
    s = idle_s();
    s.rd = 1'b1;
    return s;
  endfunction

  function automatic vec_t mkv(stim_t s, int cnt, bit empty, logic [31:0] tgt, logic [7:0] rob);
    vec_t v;
    v.s = s; v.cnt = cnt; v.empty = empty; v.tgt = tgt; v.rob = rob;
    return v;
  endfunction

  function automatic bit bc_hit(stim_t s, logic [7:0] tag, output logic [31:0] d);
    d = '0;
    if (s.bcv[0] && s.bt0 == tag) begin d = s.bd0; return 1'b1; end
    if (s.bcv[1] && s.bt1 == tag) begin d = s.bd1; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  task automatic drive(input stim_t s);
    i_flush = s.flush; i_wr_en = s.wr; i_wr_rob_addr = s.rob; i_wr_jalr = s.jalr;
    i_wr_op1 = s.op1; i_wr_op1_tag = s.t1; i_wr_op1_v = s.v1;
    i_wr_op2 = s.op2; i_wr_op2_tag = s.t2; i_wr_op2_v = s.v2;
    i_bc_valid = s.bcv; i_bc_rob_addr = {s.bt1, s.bt0}; i_bc_data = {s.bd1, s.bd0};
    i_rd_en = s.rd;
  endtask

  // Station kept as an age-ordered queue: front is oldest, so the oldest ready
  // entry is simply the first ready one found scanning from the front
  task automatic model_step(input stim_t s);
    int          r;
    bit          full0, pop;
    ment_t       e;
    fent_t       f;
    logic [31:0] d, sum;
    if (s.flush) begin
      mq.delete();
      fq.delete();
      return;
    end
    full0 = (mq.size() == RSDEPTH);
    pop = s.rd && (fq.size() > 0);
    r = -1;
    foreach (mq[i]) if (r < 0 && mq[i].v1 && mq[i].v2) r = i;
    if (pop) void'(fq.pop_front());
    if (r >= 0 && fq.size() < OFDEPTH) begin
      sum = mq[r].o1 + mq[r].o2;
      if (mq[r].jalr) sum[0] = 1'b0;
      f.tgt = sum;
      f.rob = mq[r].rob;
      fq.push_back(f);
      mq.delete(r);
    end
    foreach (mq[i]) begin
      if (!mq[i].v1 && bc_hit(s, mq[i].t1, d)) begin mq[i].o1 = d; mq[i].v1 = 1'b1; end
      if (!mq[i].v2 && bc_hit(s, mq[i].t2, d)) begin mq[i].o2 = d; mq[i].v2 = 1'b1; end
    end
    if (s.wr && !full0) begin
      e.rob = s.rob; e.jalr = s.jalr;
      e.o1 = s.op1; e.v1 = s.v1; e.t1 = s.t1;
      e.o2 = s.op2; e.v2 = s.v2; e.t2 = s.t2;
      if (!e.v1 && bc_hit(s, e.t1, d)) begin e.o1 = d; e.v1 = 1'b1; end
      if (!e.v2 && bc_hit(s, e.t2, d)) begin e.o2 = d; e.v2 = 1'b1; end
      mq.push_back(e);
    end
  endtask

  task automatic checkOutput();
    check("model_count", 32'(o_count), 32'(mq.size()));
    check("model_full", 32'(o_full), 32'(mq.size() == RSDEPTH));
    check("model_empty", 32'(o_empty), 32'(fq.size() == 0));
    if (fq.size() > 0) begin
      check("model_target", o_target, fq[0].tgt);
      check("model_rob", 32'(o_rob_addr), 32'(fq[0].rob));
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    drive(s);
    @(posedge clk);
    model_step(s);
    #1;
    checkOutput();
  endtask

  initial begin
    stim_t s;

    // Expected values below are worked out by hand from the spec's timing
    tbl[0]  = mkv(wr_s(8'h05, 0, 32'h1000, 1, 0, 32'h20, 1, 0), 1, 1, 0, 0);
    tbl[1]  = mkv(wr_s(8'h06, 0, 32'h2000, 1, 0, 32'h4, 1, 0), 1, 0, 32'h1020, 8'h05);
    tbl[2]  = mkv(wr_s(8'h07, 1, 32'h3001, 1, 0, 32'h0, 1, 0), 1, 0, 32'h1020, 8'h05);
    tbl[3]  = mkv(rd_s(), 0, 0, 32'h2004, 8'h06);
    tbl[4]  = mkv(rd_s(), 0, 0, 32'h3000, 8'h07);
    tbl[5]  = mkv(rd_s(), 0, 1, 0, 0);
    tbl[6]  = mkv(wr_s(8'h01, 0, 32'h0, 0, 8'h09, 32'h4, 1, 0), 1, 1, 0, 0);
    tbl[7]  = mkv(wr_s(8'h02, 0, 32'h0, 0, 8'h09, 32'h8, 1, 0), 2, 1, 0, 0);
    s = idle_s(); s.bcv = 2'b10; s.bt1 = 8'h09; s.bd1 = 32'h100; s.bt0 = 8'h09; s.bd0 = 32'hDEAD;
    s.bcv = 2'b10;
    tbl[8]  = mkv(s, 2, 1, 0, 0);
    tbl[9]  = mkv(idle_s(), 1, 0, 32'h104, 8'h01);
    tbl[10] = mkv(idle_s(), 0, 0, 32'h104, 8'h01);
    tbl[11] = mkv(rd_s(), 0, 0, 32'h108, 8'h02);
    tbl[12] = mkv(rd_s(), 0, 1, 0, 0);
    s = wr_s(8'h0A, 0, 32'h0, 0, 8'h03, 32'h10, 1, 0); s.bcv = 2'b01; s.bt0 = 8'h03; s.bd0 = 32'h40;
    tbl[13] = mkv(s, 1, 1, 0, 0);
    tbl[14] = mkv(idle_s(), 0, 0, 32'h50, 8'h0A);
    tbl[15] = mkv(rd_s(), 0, 1, 0, 0);

    rstn = 1'b0;
    drive(idle_s());
    #12;
    check("reset_count", 32'(o_count), 0);
    check("reset_full", 32'(o_full), 0);
    check("reset_empty", 32'(o_empty), 1);
    check("reset_target", o_target, 0);
    check("reset_rob", 32'(o_rob_addr), 0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(tbl[i].s);
      check($sformatf("tbl%0d_count", i), 32'(o_count), 32'(tbl[i].cnt));
      check($sformatf("tbl%0d_full", i), 32'(o_full), 0);
      check($sformatf("tbl%0d_empty", i), 32'(o_empty), 32'(tbl[i].empty));
      if (!tbl[i].empty) begin
        check($sformatf("tbl%0d_target", i), o_target, tbl[i].tgt);
        check($sformatf("tbl%0d_rob", i), 32'(o_rob_addr), 32'(tbl[i].rob));
      end
    end

    // Fill every entry with op1 pending, then try one more write
    for (int i = 0; i < RSDEPTH; i++)
      applyStimulus(wr_s(8'h10 + 8'(i), 0, 0, 0, 8'd20 + 8'(i), 32'(i), 1, 0));
    check("fill_full", 32'(o_full), 1);
    applyStimulus(wr_s(8'h1F, 0, 1, 1, 0, 1, 1, 0));
    check("ninth_dropped_count", 32'(o_count), 8);
    for (int i = RSDEPTH-1; i >= 0; i--) begin
      s = rd_s(); s.bcv = 2'b01; s.bt0 = 8'd20 + 8'(i); s.bd0 = 32'h1000 * 32'(i + 1);
      applyStimulus(s);
    end
    for (int i = 0; i < 6; i++) applyStimulus(rd_s());
    check("drain_count", 32'(o_count), 0);
    check("drain_empty", 32'(o_empty), 1);

    // Backpressure: six ready entries with no pops
    for (int i = 0; i < 6; i++)
      applyStimulus(wr_s(8'h20 + 8'(i), 0, 32'h100 * 32'(i), 1, 0, 32'(i), 1, 0));
    applyStimulus(idle_s());
    check("bp_held_count", 32'(o_count), 2);
    check("bp_fifo_nonempty", 32'(o_empty), 0);
    applyStimulus(rd_s());
    check("bp_one_more", 32'(o_count), 1);
    for (int i = 0; i < 8; i++) applyStimulus(rd_s());

    // Flush with three pending entries and two results waiting
    applyStimulus(wr_s(8'h30, 0, 32'h5, 1, 0, 32'h5, 1, 0));
    applyStimulus(wr_s(8'h31, 0, 32'h6, 1, 0, 32'h6, 1, 0));
    for (int i = 0; i < 3; i++)
      applyStimulus(wr_s(8'h32 + 8'(i), 0, 0, 0, 8'h50 + 8'(i), 32'h1, 1, 0));
    check("preflush_count", 32'(o_count), 3);
    s = idle_s(); s.flush = 1'b1; s.rd = 1'b1;
    applyStimulus(s);
    check("flush_count", 32'(o_count), 0);
    check("flush_empty", 32'(o_empty), 1);

    // Asynchronous reset between edges
    applyStimulus(wr_s(8'h40, 0, 32'h7, 1, 0, 32'h7, 1, 0));
    applyStimulus(wr_s(8'h41, 0, 0, 0, 8'h60, 32'h7, 1, 0));
    drive(idle_s());
    #2;
    rstn = 1'b0;
    #1;
    check("async_count", 32'(o_count), 0);
    check("async_empty", 32'(o_empty), 1);
    check("async_full", 32'(o_full), 0);
    mq.delete();
    fq.delete();
    @(negedge clk);
    rstn = 1'b1;

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      s = idle_s();
      s.flush = ($urandom_range(0, 199) == 0);
      s.wr = $urandom_range(0, 1);
      s.rob = 8'($urandom);
      s.jalr = $urandom_range(0, 1);
      s.op1 = $urandom; s.v1 = $urandom_range(0, 1); s.t1 = 8'($urandom_range(0, 7));
      s.op2 = $urandom; s.v2 = $urandom_range(0, 1); s.t2 = 8'($urandom_range(0, 7));
      s.bcv = 2'($urandom_range(0, 3));
      s.bt0 = 8'($urandom_range(0, 7)); s.bd0 = $urandom;
      s.bt1 = 8'($urandom_range(0, 7)); s.bd1 = $urandom;
      s.rd = $urandom_range(0, 1);
      applyStimulus(s);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
